// File: rtl/rv_pkg.sv
// Shared definitions for the integer register file and its users.
package rv_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  // Register file lifecycle: INIT walks every entry to zero, RUN is normal use.
  typedef enum logic {
    RF_INIT = 1'b0,
    RF_RUN  = 1'b1
  } rf_state_e;

endpackage

// File: rtl/rf_read_port.sv
// One read port: address-0 force, write-to-read forwarding and pending mask.
module rf_read_port
  import rv_pkg::*;
#(
  parameter int DATA_W = XLEN,
  parameter int ADDR_W = REG_ADDR_W,
  parameter int BYPASS = 1
) (
  input  logic              active,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] stored,
  input  logic              stored_pending,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] data,
  output logic              pending
);

  logic fwd;

  // Select forwarded, stored or forced-zero data; forwarded data is never pending.
  always_comb begin
    fwd     = (BYPASS != 0) && wr_en && (wr_addr == addr);
    data    = '0;
    pending = 1'b0;
    if (active && (addr != '0)) begin
      if (fwd) begin
        data = wr_data;
      end else begin
        data    = stored;
        pending = stored_pending;
      end
    end
  end

endmodule

// File: rtl/regfile_scoreboard.sv
// Multi-read-port integer register file with a post-reset clear sequencer,
// optional write-to-read bypass and a per-register pending (scoreboard) bit.
//
// Interface semantics: ready is a level, not a handshake. wr_en and iss_en are
// single-cycle strobes with no backpressure; every strobe present at a clock
// edge while ready is 1 takes effect at that edge, and strobes while ready is
// 0 (clear sequence running) are dropped. Read ports are purely combinational.
module regfile_scoreboard
  import rv_pkg::*;
#(
  parameter int DATA_W = XLEN,
  parameter int ADDR_W = REG_ADDR_W,
  parameter int NUM_RD = 2,
  parameter int BYPASS = 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_pending,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     iss_en,
  input  logic [ADDR_W-1:0]        iss_addr,
  output logic                     ready,
  output rf_state_e                dbg_state
);

  localparam int DEPTH = 1 << ADDR_W;

  rf_state_e         state;
  logic [ADDR_W-1:0] clr_cnt;
  logic [DATA_W-1:0] rf [DEPTH];
  logic [DEPTH-1:0]  pending;
  logic [DEPTH-1:0]  iss_dec;
  logic [DEPTH-1:0]  wr_dec;
  logic              run;

  assign run       = (state == RF_RUN);
  assign dbg_state = state;

  // Clear sequencer: walk clr_cnt over every entry, then hold in RUN.
  // The counter stops on the last index rather than wrapping.
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= RF_INIT;
      clr_cnt <= '0;
      ready   <= 1'b0;
    end else if (state == RF_INIT) begin
      if (clr_cnt == '1) begin
        state <= RF_RUN;
        ready <= 1'b1;
      end else begin
        clr_cnt <= clr_cnt + 1'b1;
      end
    end
  end

  // Storage: zero one entry per edge in INIT, writeback in RUN; entry 0 never written.
  always_ff @(posedge clock) begin
    if (!reset) begin
      if (!run) begin
        rf[clr_cnt] <= '0;
      end else if (wr_en && (wr_addr != '0)) begin
        rf[wr_addr] <= wr_data;
      end
    end
  end

  // One-hot decode of the issue and writeback destinations; entry 0 cannot be set.
  always_comb begin
    iss_dec = '0;
    wr_dec  = '0;
    if (iss_en && (iss_addr != '0)) iss_dec[iss_addr] = 1'b1;
    if (wr_en)                      wr_dec[wr_addr]   = 1'b1;
  end

  // Scoreboard: a new issue supersedes a simultaneous writeback to the same entry.
  always_ff @(posedge clock) begin
    if (reset) begin
      pending <= '0;
    end else if (run) begin
      pending <= (pending & ~wr_dec) | iss_dec;
    end
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] a;
    assign a = rd_addr[i*ADDR_W +: ADDR_W];

    rf_read_port #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .BYPASS (BYPASS)
    ) u_port (
      .active         (run),
      .addr           (a),
      .stored         (rf[a]),
      .stored_pending (pending[a]),
      .wr_en          (wr_en),
      .wr_addr        (wr_addr),
      .wr_data        (wr_data),
      .data           (rd_data[i*DATA_W +: DATA_W]),
      .pending        (rd_pending[i])
    );
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard: one bypassing and one non-bypassing instance
// share the same stimulus and are checked against a behavioural model.
module tb_regfile_scoreboard;
  import rv_pkg::*;

  logic        clock;
  logic        reset;
  logic [9:0]  rd_addr;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        iss_en;
  logic [4:0]  iss_addr;

  logic [63:0] rd_data_b, rd_data_n;
  logic [1:0]  rd_pending_b, rd_pending_n;
  logic        ready_b, ready_n;
  rf_state_e   dbg_b, dbg_n;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  logic [31:0] m_rf [32];
  bit          m_pend [32];
  bit          m_ready;
  int          m_cnt;

  regfile_scoreboard #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .BYPASS(1)) dut_b (
    .clock(clock), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data_b),
    .rd_pending(rd_pending_b), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .iss_en(iss_en), .iss_addr(iss_addr), .ready(ready_b), .dbg_state(dbg_b)
  );

  regfile_scoreboard #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .BYPASS(0)) dut_n (
    .clock(clock), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data_n),
    .rd_pending(rd_pending_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .iss_en(iss_en), .iss_addr(iss_addr), .ready(ready_n), .dbg_state(dbg_n)
  );

  // Clock / reset block
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Model: advance one clock edge using the inputs present at that edge.
  task automatic model_update();
    if (reset) begin
      m_ready = 1'b0;
      m_cnt   = 0;
      for (int r = 0; r < 32; r++) m_pend[r] = 1'b0;
    end else if (!m_ready) begin
      m_rf[m_cnt] = 32'h0;
      m_cnt++;
      if (m_cnt == 32) m_ready = 1'b1;
    end else begin
      if (wr_en && wr_addr != 5'd0) m_rf[wr_addr] = wr_data;
      if (wr_en) m_pend[wr_addr] = 1'b0;
      if (iss_en && iss_addr != 5'd0) m_pend[iss_addr] = 1'b1;
    end
  endtask

  // Driver: cross one edge, update the model, return 1 time unit after the edge.
  task automatic tick();
    @(posedge clock);
    model_update();
    #1;
  endtask

  task automatic idle_inputs();
    wr_en = 1'b0; wr_addr = 5'd0; wr_data = 32'h0;
    iss_en = 1'b0; iss_addr = 5'd0; rd_addr = 10'd0;
  endtask

  task automatic random_inputs();
    wr_en    = 1'($urandom_range(0, 1));
    wr_addr  = 5'($urandom_range(0, 31));
    wr_data  = $urandom;
    iss_en   = ($urandom_range(0, 2) == 0);
    iss_addr = ($urandom_range(0, 3) == 0) ? wr_addr : 5'($urandom_range(0, 31));
    rd_addr[4:0] = ($urandom_range(0, 2) == 0) ? wr_addr : 5'($urandom_range(0, 31));
    rd_addr[9:5] = ($urandom_range(0, 3) == 0) ? iss_addr : 5'($urandom_range(0, 31));
  endtask

  function automatic logic [63:0] exp_data(input bit byp);
    logic [63:0] v;
    int a;
    v = '0;
    for (int p = 0; p < 2; p++) begin
      a = int'(rd_addr[p*5 +: 5]);
      if (!m_ready || a == 0)                         v[p*32 +: 32] = 32'h0;
      else if (byp && wr_en && int'(wr_addr) == a)    v[p*32 +: 32] = wr_data;
      else                                            v[p*32 +: 32] = m_rf[a];
    end
    return v;
  endfunction

  function automatic logic [1:0] exp_pend(input bit byp);
    logic [1:0] v;
    int a;
    v = '0;
    for (int p = 0; p < 2; p++) begin
      a = int'(rd_addr[p*5 +: 5]);
      if (!m_ready || a == 0)                         v[p] = 1'b0;
      else if (byp && wr_en && int'(wr_addr) == a)    v[p] = 1'b0;
      else                                            v[p] = m_pend[a];
    end
    return v;
  endfunction

  task automatic test_reset();
    int edges;
    idle_inputs();
    reset = 1'b1;
    repeat (3) tick();
    #4;
    checks++;
    if (ready_b !== 1'b0 || ready_n !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready got %b/%b expected 0/0", ready_b, ready_n);
    end
    tick();
    reset = 1'b0;
    edges = 0;
    while (ready_b !== 1'b1 && edges < 100) begin
      rd_addr = 10'($urandom);
      wr_en = 1'b1; wr_addr = 5'($urandom_range(1, 31)); wr_data = $urandom;
      #4;
      checks++;
      if (rd_data_b !== 64'h0 || rd_pending_b !== 2'b00 || dbg_b !== RF_INIT) begin
        errors++;
        $display("FAIL init_reads got %h/%b expected 0/00", rd_data_b, rd_pending_b);
      end
      tick();
      edges++;
    end
    idle_inputs();
    checks++;
    if (edges != 32 || ready_n !== 1'b1 || m_ready != 1'b1) begin
      errors++;
      $display("FAIL init_length got %0d edges (ready_n %b) expected 32", edges, ready_n);
    end
    for (int a = 0; a < 32; a++) begin
      rd_addr = {5'(31 - a), 5'(a)};
      #4;
      checks++;
      if (rd_data_b !== 64'h0 || rd_data_n !== 64'h0 ||
          rd_pending_b !== 2'b00 || rd_pending_n !== 2'b00) begin
        errors++;
        $display("FAIL clear_sweep a=%0d got %h/%h expected 0", a, rd_data_b, rd_data_n);
      end
      tick();
    end
  endtask

  task automatic test_write();
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF;
    tick();
    idle_inputs();
    rd_addr[4:0] = 5'd5;
    #4;
    checks++;
    if (rd_data_b[31:0] !== 32'hDEADBEEF || rd_data_n[31:0] !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL write_r5 got %h/%h expected deadbeef", rd_data_b[31:0], rd_data_n[31:0]);
    end
    tick();
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h12345678;
    rd_addr[9:5] = 5'd0;
    #4;
    checks++;
    if (rd_data_b[63:32] !== 32'h0) begin
      errors++;
      $display("FAIL write_r0_bypass got %h expected 0", rd_data_b[63:32]);
    end
    tick();
    wr_en = 1'b0;
    #4;
    checks++;
    if (rd_data_b[63:32] !== 32'h0 || rd_data_n[63:32] !== 32'h0 ||
        rd_data_b[31:0] !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL write_r0 got %h/%h expected 0 and deadbeef", rd_data_b[63:32], rd_data_b[31:0]);
    end
    tick();
  endtask

  task automatic test_bypass();
    idle_inputs();
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h11111111;
    tick();
    idle_inputs();
    iss_en = 1'b1; iss_addr = 5'd7;
    tick();
    idle_inputs();
    rd_addr[4:0] = 5'd7;
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'hA5A5A5A5;
    #4;
    checks++;
    if (rd_data_b[31:0] !== 32'hA5A5A5A5 || rd_pending_b[0] !== 1'b0) begin
      errors++;
      $display("FAIL bypass_same_cycle got %h/%b expected a5a5a5a5/0", rd_data_b[31:0], rd_pending_b[0]);
    end
    checks++;
    if (rd_data_n[31:0] !== 32'h11111111 || rd_pending_n[0] !== 1'b1) begin
      errors++;
      $display("FAIL nobypass_same_cycle got %h/%b expected 11111111/1", rd_data_n[31:0], rd_pending_n[0]);
    end
    tick();
    wr_en = 1'b0;
    #4;
    checks++;
    if (rd_data_n[31:0] !== 32'hA5A5A5A5 || rd_pending_n[0] !== 1'b0 ||
        rd_data_b[31:0] !== 32'hA5A5A5A5) begin
      errors++;
      $display("FAIL nobypass_next_cycle got %h/%b expected a5a5a5a5/0", rd_data_n[31:0], rd_pending_n[0]);
    end
    tick();
  endtask

  task automatic test_pending();
    idle_inputs();
    rd_addr = {5'd9, 5'd9};
    iss_en = 1'b1; iss_addr = 5'd9;
    tick();
    iss_en = 1'b0;
    #4;
    checks++;
    if (rd_pending_b !== 2'b11 || rd_pending_n !== 2'b11) begin
      errors++;
      $display("FAIL issue_r9 got %b/%b expected 11/11", rd_pending_b, rd_pending_n);
    end
    tick();
    iss_en = 1'b1; iss_addr = 5'd9;
    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h0BADF00D;
    tick();
    iss_en = 1'b0; wr_en = 1'b0;
    #4;
    checks++;
    if (rd_pending_b !== 2'b11 || rd_pending_n !== 2'b11) begin
      errors++;
      $display("FAIL issue_wins got %b/%b expected 11/11", rd_pending_b, rd_pending_n);
    end
    tick();
    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h600DF00D;
    tick();
    wr_en = 1'b0;
    #4;
    checks++;
    if (rd_pending_b !== 2'b00 || rd_pending_n !== 2'b00 || rd_data_n[31:0] !== 32'h600DF00D) begin
      errors++;
      $display("FAIL wb_clears got %b/%b expected 00/00", rd_pending_b, rd_pending_n);
    end
    tick();
    rd_addr = 10'd0;
    iss_en = 1'b1; iss_addr = 5'd0;
    tick();
    iss_en = 1'b0;
    #4;
    checks++;
    if (rd_pending_b !== 2'b00 || rd_pending_n !== 2'b00) begin
      errors++;
      $display("FAIL issue_r0 got %b/%b expected 00/00", rd_pending_b, rd_pending_n);
    end
    tick();
    iss_en = 1'b1; iss_addr = 5'd4;
    tick();
    iss_en = 1'b1; iss_addr = 5'd3;
    wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'hCAFE0004;
    tick();
    idle_inputs();
    rd_addr = {5'd4, 5'd3};
    #4;
    checks++;
    if (rd_pending_b !== 2'b01 || rd_pending_n !== 2'b01) begin
      errors++;
      $display("FAIL issue_and_wb got %b/%b expected 01/01", rd_pending_b, rd_pending_n);
    end
    tick();
  endtask

  task automatic test_random();
    logic [63:0] ed;
    logic [1:0]  ep;
    for (int i = 0; i < 400; i++) begin
      random_inputs();
      #4;
      ed = exp_data(1'b1);
      ep = exp_pend(1'b1);
      checks++;
      if (rd_data_b !== ed || rd_pending_b !== ep) begin
        errors++;
        $display("FAIL random_bypass i=%0d got %h/%b expected %h/%b", i, rd_data_b, rd_pending_b, ed, ep);
      end
      ed = exp_data(1'b0);
      ep = exp_pend(1'b0);
      checks++;
      if (rd_data_n !== ed || rd_pending_n !== ep) begin
        errors++;
        $display("FAIL random_nobypass i=%0d got %h/%b expected %h/%b", i, rd_data_n, rd_pending_n, ed, ep);
      end
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_reset_restart();
    int edges;
    idle_inputs();
    wr_en = 1'b1; wr_addr = 5'd13; wr_data = 32'h13131313;
    iss_en = 1'b1; iss_addr = 5'd12;
    tick();
    idle_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      random_inputs();
      tick();
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    edges = 0;
    while (ready_b !== 1'b1 && edges < 100) begin
      random_inputs();
      #4;
      checks++;
      if (rd_data_b !== 64'h0 || rd_pending_n !== 2'b00 || ready_n !== 1'b0) begin
        errors++;
        $display("FAIL restart_init got %h/%b expected 0/00", rd_data_b, rd_pending_n);
      end
      tick();
      edges++;
    end
    idle_inputs();
    checks++;
    if (edges != 32 || ready_n !== 1'b1) begin
      errors++;
      $display("FAIL restart_length got %0d edges expected 32", edges);
    end
    for (int a = 0; a < 32; a++) begin
      rd_addr = {5'(a), 5'(a)};
      #4;
      checks++;
      if (rd_data_b !== exp_data(1'b1) || rd_data_n !== 64'h0 ||
          rd_pending_b !== 2'b00 || rd_pending_n !== 2'b00) begin
        errors++;
        $display("FAIL restart_sweep a=%0d got %h/%b expected 0/00", a, rd_data_n, rd_pending_b);
      end
      tick();
    end
  endtask

  initial begin
    for (int r = 0; r < 32; r++) begin
      m_rf[r]   = 32'h0;
      m_pend[r] = 1'b0;
    end
    m_ready = 1'b0;
    m_cnt   = 0;
    reset   = 1'b1;
    idle_inputs();
    test_reset();
    test_write();
    test_bypass();
    test_pending();
    test_random();
    test_reset_restart();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
